// File: rtl/t03_wb_arbiter.sv
// t03_wb_arbiter
// Two-requester arbiter sharing one Wishbone manager port between the CPU
// instruction-fetch port (M0, read only) and the MMIO data side (M1).
// Ties are resolved round-robin. A granted transaction is latched onto the
// bus until bus_ack, then answered with a one-cycle ack pulse.
// Optional build macro: T03_ARB_TIMEOUT_EN -- a bus cycle that sees no
// bus_ack within TIMEOUT_CYCLES busy cycles is aborted and completed with
// 32'hDEADBEEF, with a one-cycle bus_timeout pulse.

module t03_wb_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_addr,
   input  logic        if_ren,
   output logic [31:0] if_data,
   output logic        if_ack,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_sel,
   input  logic        d_wen,
   input  logic        d_ren,
   output logic [31:0] d_data,
   output logic        d_ack,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_do,
   output logic [3:0]  bus_sel,
   output logic        bus_wen,
   output logic        bus_ren,
   input  logic [31:0] bus_di,
   input  logic        bus_ack,
   output logic        bus_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic PORT_M0 = 1'b0;
   localparam logic PORT_M1 = 1'b1;

   state_t      state_r;
   logic        last_grant_r;
   logic        grant_r;
   logic        req0_s;
   logic        req1_s;
   logic        pick_s;
   logic        abort_s;
   logic [31:0] done_data_s;

   assign req0_s = if_ren;
   assign req1_s = d_wen | d_ren;

   // Choose the port to grant: the lone requester, or on a tie the port
   // that did not win last time
   always_comb begin
      pick_s = PORT_M0;
      if (req0_s && req1_s) begin
         pick_s = ~last_grant_r;
      end else if (req1_s) begin
         pick_s = PORT_M1;
      end else begin
         pick_s = PORT_M0;
      end
   end

   // Data returned to the granted port: bus read data on a real ack,
   // the poison word when the cycle is aborted
   always_comb begin
      done_data_s = 32'h0000_0000;
      if (bus_ack) begin
         done_data_s = bus_di;
      end else begin
         done_data_s = 32'hDEAD_BEEF;
      end
   end

`ifdef T03_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] busy_cnt_r;

   // Count completed BUSY cycles; held at zero outside BUSY so every
   // transaction starts counting from zero
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r != ST_BUSY) begin
         busy_cnt_r <= {CNT_W{1'b0}};
      end else begin
         busy_cnt_r <= busy_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Abort at the end of the TIMEOUT_CYCLES-th busy cycle; a bus_ack in
   // that same cycle wins and completes normally
   assign abort_s = (state_r == ST_BUSY) && !bus_ack && (busy_cnt_r == CNT_LAST);
`else
   // Without the timeout build a bus cycle waits for bus_ack indefinitely
   assign abort_s = 1'b0;
`endif

   // Arbitration FSM; owns every registered output of the block
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         last_grant_r <= PORT_M1;
         grant_r      <= PORT_M0;
         bus_addr     <= 32'h0000_0000;
         bus_do       <= 32'h0000_0000;
         bus_sel      <= 4'h0;
         bus_wen      <= 1'b0;
         bus_ren      <= 1'b0;
         if_data      <= 32'h0000_0000;
         d_data       <= 32'h0000_0000;
         if_ack       <= 1'b0;
         d_ack        <= 1'b0;
         bus_timeout  <= 1'b0;
      end else begin
         if_ack      <= 1'b0;
         d_ack       <= 1'b0;
         bus_timeout <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req0_s || req1_s) begin
                  grant_r      <= pick_s;
                  last_grant_r <= pick_s;
                  state_r      <= ST_BUSY;
                  if (pick_s == PORT_M0) begin
                     bus_addr <= if_addr;
                     bus_do   <= 32'h0000_0000;
                     bus_sel  <= 4'hF;
                     bus_wen  <= 1'b0;
                     bus_ren  <= 1'b1;
                  end else begin
                     // a simultaneous write and read request is a write
                     bus_addr <= d_addr;
                     bus_do   <= d_wdata;
                     bus_sel  <= d_sel;
                     bus_wen  <= d_wen;
                     bus_ren  <= ~d_wen;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (bus_ack || abort_s) begin
                  bus_wen     <= 1'b0;
                  bus_ren     <= 1'b0;
                  bus_timeout <= abort_s;
                  state_r     <= ST_RESP;
                  if (grant_r == PORT_M0) begin
                     if_data <= done_data_s;
                     if_ack  <= 1'b1;
                  end else begin
                     d_data  <= done_data_s;
                     d_ack   <= 1'b1;
                  end
               end else begin
                  state_r <= ST_BUSY;
               end
            end
            ST_RESP: begin
               // ack is visible in this cycle; no grant until back in IDLE
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_t03_wb_arbiter.sv
// Self-checking bench for t03_wb_arbiter. The stimulus process plays both
// requesters and the bus slave; expected completions are queued when the
// slave answers and a monitor process checks grants, acks and data.
module tb_t03_wb_arbiter;

`ifdef T03_ARB_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] if_addr, if_data, d_addr, d_wdata, d_data;
   logic [31:0] bus_addr, bus_do, bus_di;
   logic        if_ren, if_ack, d_wen, d_ren, d_ack;
   logic        bus_wen, bus_ren, bus_ack, bus_timeout;
   logic [3:0]  d_sel, bus_sel;

   t03_wb_arbiter #(.TIMEOUT_CYCLES(TO_CYC)) dut (
      .clk(clk), .rst(rst),
      .if_addr(if_addr), .if_ren(if_ren), .if_data(if_data), .if_ack(if_ack),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel), .d_wen(d_wen),
      .d_ren(d_ren), .d_data(d_data), .d_ack(d_ack),
      .bus_addr(bus_addr), .bus_do(bus_do), .bus_sel(bus_sel),
      .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_di(bus_di),
      .bus_ack(bus_ack), .bus_timeout(bus_timeout)
   );

   typedef struct {
      logic        port;
      logic [31:0] data;
      int          at;
      logic        to;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   exp_t exp_q[$];
   logic grant_log[$];
   logic cur_port = 1'b0;
   logic last_win = 1'b1;
   logic [31:0] exp_if_data = 32'h0;
   logic [31:0] exp_d_data  = 32'h0;

   // stimulus knobs and requester/slave state
   int          new_pct     = 0;
   bit          freeze      = 1'b1;
   int          slave_delay = -1;
   bit          slave_hold  = 1'b0;
   bit          spurious    = 1'b0;
   bit          fix_di      = 1'b0;
   logic [31:0] fix_di_val  = 32'h0;
   bit          m0_act      = 1'b0;
   bit          m1_act      = 1'b0;
   bit          ack_issued  = 1'b0;
   int          dly         = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, want);
      end
   endtask

   // one cycle of requester and bus-slave behaviour, driven at the negedge
   task automatic tick();
      int   kind;
      exp_t e;
      @(negedge clk);
      if (!freeze) begin
         if (m0_act && if_ack) begin
            if_ren = 1'b0;
            m0_act = 1'b0;
         end else if (!m0_act && $urandom_range(99) < new_pct) begin
            if_ren  = 1'b1;
            if_addr = $urandom;
            m0_act  = 1'b1;
         end
         if (m1_act && d_ack) begin
            d_wen  = 1'b0;
            d_ren  = 1'b0;
            m1_act = 1'b0;
         end else if (!m1_act && $urandom_range(99) < new_pct) begin
            kind    = $urandom_range(2);
            d_addr  = $urandom;
            d_wdata = $urandom;
            d_sel   = 4'($urandom);
            d_wen   = (kind != 0);
            d_ren   = (kind != 1);
            m1_act  = 1'b1;
         end
      end
      bus_ack = 1'b0;
      if (bus_ren || bus_wen) begin
         if (!ack_issued && !slave_hold) begin
            if (dly == 0) begin
               bus_ack = 1'b1;
               bus_di  = fix_di ? fix_di_val : $urandom;
               e.port  = cur_port;
               e.data  = bus_di;
               e.at    = cyc + 1;
               e.to    = 1'b0;
               exp_q.push_back(e);
               ack_issued = 1'b1;
            end else begin
               dly--;
            end
         end
      end else begin
         ack_issued = 1'b0;
         dly = (slave_delay < 0) ? $urandom_range(3) : slave_delay;
         if (spurious && $urandom_range(3) == 0) begin
            bus_ack = 1'b1;
            bus_di  = $urandom;
         end
      end
   endtask

   task automatic wait_idle(input string name, input int limit);
      int n = 0;
      while ((m0_act || m1_act) && n < limit) begin
         tick();
         n++;
      end
      check(name, {30'h0, m0_act, m1_act}, 32'h0);
      tick();
   endtask

   task automatic tick_until_strobe(input string name, input int limit);
      int n = 0;
      while (!(bus_ren || bus_wen) && n < limit) begin
         tick();
         n++;
      end
      check(name, {31'h0, bus_ren | bus_wen}, 32'h1);
   endtask

   task automatic do_reset(input int n);
      freeze = 1'b1;
      rst    = 1'b0;
      if_ren = 1'b0;
      d_wen  = 1'b0;
      d_ren  = 1'b0;
      m0_act = 1'b0;
      m1_act = 1'b0;
      repeat (n) tick();
      rst    = 1'b1;
      freeze = 1'b0;
   endtask

   task automatic raise_both();
      if_ren  = 1'b1; if_addr = $urandom; m0_act = 1'b1;
      d_wen   = 1'b0; d_ren   = 1'b1;     d_addr = $urandom;
      d_wdata = $urandom; d_sel = 4'($urandom); m1_act = 1'b1;
   endtask

   // Monitor: reference arbitration model and completion scoreboard
   initial begin : monitor
      logic        s_rst, s_ifren, s_dwen, s_dren, r0, r1, want, strobe;
      logic        prev_strobe, prev_ack, h_wen;
      logic [31:0] s_ifaddr, s_daddr, s_dwdata, h_addr;
      logic [3:0]  s_dsel, h_sel;
      exp_t        e;
      prev_strobe = 1'b0; prev_ack = 1'b0;
      h_addr = 32'h0; h_sel = 4'h0; h_wen = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         s_rst = rst; s_ifren = if_ren; s_dwen = d_wen; s_dren = d_ren;
         s_ifaddr = if_addr; s_daddr = d_addr; s_dwdata = d_wdata; s_dsel = d_sel;
         #1;
         if (!s_rst) begin
            check("rst_ctrl", {27'h0, bus_ren, bus_wen, if_ack, d_ack, bus_timeout}, 32'h0);
            check("rst_addr", bus_addr, 32'h0);
            check("rst_do", bus_do, 32'h0);
            check("rst_sel", {28'h0, bus_sel}, 32'h0);
            check("rst_if_data", if_data, 32'h0);
            check("rst_d_data", d_data, 32'h0);
            last_win = 1'b1; exp_if_data = 32'h0; exp_d_data = 32'h0;
            exp_q.delete(); prev_strobe = 1'b0; prev_ack = 1'b0;
         end else begin
            strobe = bus_ren | bus_wen;
            check("one_strobe", {31'h0, bus_ren & bus_wen}, 32'h0);
            if (strobe && !prev_strobe) begin
               r0 = s_ifren;
               r1 = s_dwen | s_dren;
               check("grant_has_req", {31'h0, r0 | r1}, 32'h1);
               want   = (r0 && r1) ? ~last_win : r1;
               h_addr = want ? s_daddr : s_ifaddr;
               h_sel  = want ? s_dsel : 4'hF;
               h_wen  = want & s_dwen;
               check("grant_addr", bus_addr, h_addr);
               check("grant_sel", {28'h0, bus_sel}, {28'h0, h_sel});
               check("grant_wen", {31'h0, bus_wen}, {31'h0, h_wen});
               check("grant_ren", {31'h0, bus_ren}, {31'h0, ~h_wen});
               if (want) check("grant_wdata", bus_do, s_dwdata);
               last_win = want;
               cur_port = want;
               grant_log.push_back(want);
            end else if (strobe) begin
               check("hold_addr", bus_addr, h_addr);
               check("hold_sel", {28'h0, bus_sel}, {28'h0, h_sel});
               check("hold_wen", {31'h0, bus_wen}, {31'h0, h_wen});
            end
            check("dual_ack", {31'h0, if_ack & d_ack}, 32'h0);
            if (if_ack || d_ack) begin
               check("ack_width", {31'h0, prev_ack}, 32'h0);
               if (exp_q.size() == 0) begin
                  check("unexpected_ack", {30'h0, if_ack, d_ack}, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("ack_port", {31'h0, d_ack}, {31'h0, e.port});
                  check("ack_cycle", cyc, e.at);
                  check("ack_timeout", {31'h0, bus_timeout}, {31'h0, e.to});
                  if (e.port) exp_d_data = e.data;
                  else        exp_if_data = e.data;
               end
            end else begin
               check("timeout_quiet", {31'h0, bus_timeout}, 32'h0);
               if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
                  e = exp_q.pop_front();
                  check("missing_ack", {30'h0, if_ack, d_ack}, e.port ? 32'h1 : 32'h2);
               end
            end
            check("if_data", if_data, exp_if_data);
            check("d_data", d_data, exp_d_data);
            prev_strobe = strobe;
            prev_ack    = if_ack | d_ack;
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic
   initial begin : stim
      rst = 1'b0; if_ren = 1'b1; if_addr = 32'h0000_0100;
      d_wen = 1'b0; d_ren = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_sel = 4'h0;
      bus_ack = 1'b0; bus_di = 32'h0;
      m0_act = 1'b1; freeze = 1'b1;
      slave_delay = 2; fix_di = 1'b1; fix_di_val = 32'h1234_5678;

      // reset held two cycles with a fetch pending, then the single read
      tick(); tick();
      rst = 1'b1;
      @(posedge clk); #2;
      check("rst_release_ren", {31'h0, bus_ren}, 32'h1);
      check("rst_release_addr", bus_addr, 32'h0000_0100);
      freeze = 1'b0;
      wait_idle("single_done", 20);
      check("single_if_data", if_data, 32'h1234_5678);
      fix_di = 1'b0;

      // back-to-back ties after reset: M0, M1, M0
      do_reset(2);
      slave_delay = 1;
      grant_log.delete();
      new_pct = 100;
      for (int i = 0; i < 60 && grant_log.size() < 3; i++) tick();
      new_pct = 0;
      if (grant_log.size() < 3) begin
         check("tie_count", grant_log.size(), 3);
      end else begin
         check("tie_order0", {31'h0, grant_log[0]}, 32'h0);
         check("tie_order1", {31'h0, grant_log[1]}, 32'h1);
         check("tie_order2", {31'h0, grant_log[2]}, 32'h0);
      end
      wait_idle("tie_done", 40);

      // write and read together is a write
      slave_delay = -1;
      d_addr = 32'h0000_2000; d_wdata = 32'hCAFE_0001; d_sel = 4'b0011;
      d_wen = 1'b1; d_ren = 1'b1; m1_act = 1'b1;
      @(posedge clk); #2;
      check("wp_wen", {31'h0, bus_wen}, 32'h1);
      check("wp_ren", {31'h0, bus_ren}, 32'h0);
      check("wp_sel", {28'h0, bus_sel}, 32'h3);
      check("wp_do", bus_do, 32'hCAFE_0001);
      wait_idle("wp_done", 20);

      // reset while a fetch is on the bus, then the first tie goes to M0
      slave_hold = 1'b1;
      if_ren = 1'b1; if_addr = $urandom; m0_act = 1'b1;
      tick_until_strobe("midbusy_strobe", 10);
      do_reset(1);
      slave_hold = 1'b0;
      tick();
      grant_log.delete();
      raise_both();
      for (int i = 0; i < 10 && grant_log.size() == 0; i++) tick();
      if (grant_log.size() == 0) check("post_rst_grant", 32'h0, 32'h1);
      else check("post_rst_tie", {31'h0, grant_log[0]}, 32'h0);
      wait_idle("post_rst_done", 40);

`ifdef T03_ARB_TIMEOUT_EN
      // no bus_ack at all: abort with the poison word
      begin
         exp_t e;
         slave_hold = 1'b1;
         d_addr = $urandom; d_wen = 1'b0; d_ren = 1'b1; m1_act = 1'b1;
         tick_until_strobe("to_strobe", 10);
         e.port = 1'b1; e.data = 32'hDEAD_BEEF; e.at = cyc + TO_CYC; e.to = 1'b1;
         exp_q.push_back(e);
         wait_idle("to_done", 20);
         slave_hold = 1'b0;
      end
`endif

      // randomized traffic with spurious acks while the bus is idle
      spurious = 1'b1;
      slave_delay = -1;
      for (int seg = 0; seg < 20; seg++) begin
         new_pct = $urandom_range(100, 5);
         repeat (150) tick();
      end
      new_pct = 0;
      wait_idle("drain", 100);
      repeat (3) tick();
      check("queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Bound on total run time
   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
